// File: rtl/regfile_mp.sv
// Multi-port x/f register file with write-to-read bypass and a per-register busy scoreboard.
// Optional NaN-boxing of single-precision f-bank writes: define REGFILE_MP_NANBOX_EN.
module regfile_mp_rd #(
  parameter int XLEN = 64,
  parameter int NWR  = 2
) (
  input  logic                          rst,
  input  logic [4:0]                    addr,
  input  logic                          fp,
  input  logic [1:0][31:0][XLEN-1:0]    regs,
  input  logic [1:0][31:0]              sb,
  input  logic [NWR-1:0]                wr_ok,
  input  logic [NWR-1:0]                wr_fp,
  input  logic [NWR-1:0][4:0]           wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]      wdat,
  output logic [XLEN-1:0]               data,
  output logic                          busy
);
  always_comb begin
    data = regs[fp][addr];
    busy = sb[fp][addr];
    // Ascending scan so the highest-indexed matching write port wins.
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j] && wr_fp[j] == fp && wr_addr[j] == addr) begin
        data = wdat[j];
        busy = 1'b0;
      end
    end
    if (!rst) begin
      data = '0;
      busy = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NRD  = 3,
  parameter int NWR  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRD-1:0][4:0]      rd_addr,
  input  logic [NRD-1:0]           rd_fp,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0]           wr_fp,
  input  logic [NWR-1:0][4:0]      wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic [NWR-1:0]           wr_single,
  input  logic                     iss_valid,
  input  logic                     iss_fp,
  input  logic [4:0]               iss_rd
);
  logic [1:0][31:0][XLEN-1:0] regs;
  logic [1:0][31:0]           sb;
  logic [NWR-1:0][XLEN-1:0]   wdat;
  logic [NWR-1:0]             wr_ok;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    // x0 writes are dropped here so neither storage nor bypass ever sees them.
    assign wr_ok[j] = wr_en[j] && (wr_fp[j] || wr_addr[j] != 5'd0);
`ifdef REGFILE_MP_NANBOX_EN
    assign wdat[j] = (wr_fp[j] && wr_single[j]) ?
                     {{(XLEN-32){1'b1}}, wr_data[j][31:0]} : wr_data[j];
`else
    assign wdat[j] = wr_data[j];
`endif
  end

`ifndef REGFILE_MP_NANBOX_EN
  logic unused_single;
  assign unused_single = ^wr_single;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
      sb   <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) begin
          regs[wr_fp[j]][wr_addr[j]] <= wdat[j];
          sb[wr_fp[j]][wr_addr[j]]   <= 1'b0;
        end
      end
      // Issue comes last so a new producer keeps the register busy.
      if (iss_valid && (iss_fp || iss_rd != 5'd0))
        sb[iss_fp][iss_rd] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_mp_rd #(.XLEN(XLEN), .NWR(NWR)) u_rd (
      .rst     (rst),
      .addr    (rd_addr[i]),
      .fp      (rd_fp[i]),
      .regs    (regs),
      .sb      (sb),
      .wr_ok   (wr_ok),
      .wr_fp   (wr_fp),
      .wr_addr (wr_addr),
      .wdat    (wdat),
      .data    (rd_data[i]),
      .busy    (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, reset corner case, then random traffic vs a model.
module tb_regfile_mp;
  localparam int XLEN = 64, NRD = 3, NWR = 2;

  logic clk = 1'b0, rst = 1'b0;
  logic [NRD-1:0][4:0]      rd_addr;
  logic [NRD-1:0]           rd_fp;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           wr_en, wr_fp, wr_single;
  logic [NWR-1:0][4:0]      wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;
  logic                     iss_valid, iss_fp;
  logic [4:0]               iss_rd;

  int chk = 0, err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_fp(rd_fp), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_fp(wr_fp), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_single(wr_single), .iss_valid(iss_valid),
    .iss_fp(iss_fp), .iss_rd(iss_rd)
  );

  typedef struct {
    logic [1:0]  we, wfp, ws;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic        iv, ifp;
    logic [4:0]  ird;
    logic        rfp;
    logic [4:0]  ra;
    logic [63:0] ed;
    logic        eb;
  } vec_t;

  vec_t vecs[22];
  logic [63:0] mreg [2][32];
  logic        mbusy[2][32];

  task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [63:0] box(input logic fp, input logic s, input logic [63:0] d);
`ifdef REGFILE_MP_NANBOX_EN
    if (fp && s) return {32'hFFFF_FFFF, d[31:0]};
`endif
    return d;
  endfunction

  function automatic vec_t mk(input logic [1:0] we, input logic [1:0] wfp, input logic [1:0] ws,
                              input logic [4:0] wa0, input logic [63:0] wd0,
                              input logic [4:0] wa1, input logic [63:0] wd1,
                              input logic iv, input logic ifp, input logic [4:0] ird,
                              input logic rfp, input logic [4:0] ra,
                              input logic [63:0] ed, input logic eb);
    vec_t v;
    v.we = we; v.wfp = wfp; v.ws = ws; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ifp = ifp; v.ird = ird; v.rfp = rfp; v.ra = ra; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  task automatic idle();
    wr_en = '0; wr_fp = '0; wr_single = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_fp = 1'b0; iss_rd = '0;
  endtask

  initial begin
    logic [63:0] nb_exp;
    idle();
    rd_addr = '0; rd_fp = '0;
`ifdef REGFILE_MP_NANBOX_EN
    nb_exp = 64'hFFFF_FFFF_3F80_0000;
`else
    nb_exp = 64'h0000_0000_3F80_0000;
`endif
    //            we     wfp    ws     wa0 wd0       wa1 wd1     iv ifp ird rfp ra  ed                     eb
    vecs[0]  = mk(2'b01, 2'b00, 2'b00, 0, 64'hDEAD,  0, 0,       0, 0, 0,  0, 0,  64'h0,                 0);
    vecs[1]  = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 0,  64'h0,                 0);
    vecs[2]  = mk(2'b01, 2'b00, 2'b00, 7, 64'h1234,  0, 0,       0, 0, 0,  0, 7,  64'h1234,              0);
    vecs[3]  = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 7,  64'h1234,              0);
    vecs[4]  = mk(2'b11, 2'b11, 2'b00, 3, 64'hAAAA,  3, 64'hBBBB,0, 0, 0,  1, 3,  64'hBBBB,              0);
    vecs[5]  = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  1, 3,  64'hBBBB,              0);
    vecs[6]  = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 3,  64'h0,                 0);
    vecs[7]  = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       1, 0, 9,  0, 9,  64'h0,                 0);
    vecs[8]  = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 9,  64'h0,                 1);
    vecs[9]  = mk(2'b10, 2'b00, 2'b00, 0, 0,         9, 64'h55,  0, 0, 0,  0, 9,  64'h55,                0);
    vecs[10] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 9,  64'h55,                0);
    vecs[11] = mk(2'b01, 2'b00, 2'b00, 9, 64'h66,    0, 0,       1, 0, 9,  0, 9,  64'h66,                0);
    vecs[12] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 9,  64'h66,                1);
    vecs[13] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       1, 0, 0,  0, 0,  64'h0,                 0);
    vecs[14] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 0,  64'h0,                 0);
    vecs[15] = mk(2'b01, 2'b01, 2'b01, 2, 64'h3F80_0000, 0, 0,   0, 0, 0,  1, 2,  nb_exp,                0);
    vecs[16] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  1, 2,  nb_exp,                0);
    vecs[17] = mk(2'b01, 2'b00, 2'b01, 2, 64'h3F80_0000, 0, 0,   0, 0, 0,  0, 2,  64'h0000_0000_3F80_0000, 0);
    vecs[18] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       1, 1, 5,  0, 5,  64'h0,                 0);
    vecs[19] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  1, 5,  64'h0,                 1);
    vecs[20] = mk(2'b01, 2'b00, 2'b00, 5, 64'h77,    0, 0,       0, 0, 0,  1, 5,  64'h0,                 1);
    vecs[21] = mk(2'b00, 2'b00, 2'b00, 0, 0,         0, 0,       0, 0, 0,  0, 5,  64'h77,                0);

    // Reset state on all ports: x1, f1, x0.
    #2;
    rd_addr[0] = 5'd1; rd_fp[0] = 1'b0;
    rd_addr[1] = 5'd1; rd_fp[1] = 1'b1;
    rd_addr[2] = 5'd0; rd_fp[2] = 1'b0;
    #1;
    for (int i = 0; i < NRD; i++) begin
      check("rst_data", i, rd_data[i], 64'h0);
      check("rst_busy", i, {63'h0, rd_busy[i]}, 64'h0);
    end
    @(negedge clk); rst = 1'b1;

    // Directed vector table, one cycle per entry.
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      wr_en = vecs[k].we; wr_fp = vecs[k].wfp; wr_single = vecs[k].ws;
      wr_addr[0] = vecs[k].wa0; wr_data[0] = vecs[k].wd0;
      wr_addr[1] = vecs[k].wa1; wr_data[1] = vecs[k].wd1;
      iss_valid = vecs[k].iv; iss_fp = vecs[k].ifp; iss_rd = vecs[k].ird;
      rd_addr[0] = vecs[k].ra; rd_fp[0] = vecs[k].rfp;
      #1;
      check("vec_data", k, rd_data[0], vecs[k].ed);
      check("vec_busy", k, {63'h0, rd_busy[0]}, {63'h0, vecs[k].eb});
    end

    // Reset mid-traffic: busy x4 plus a pending write to x7 must vanish without a clock edge.
    @(negedge clk); idle(); iss_valid = 1'b1; iss_rd = 5'd4;
    @(negedge clk); idle();
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 64'hCAFE;
    rd_addr[0] = 5'd4; rd_fp[0] = 1'b0;
    rd_addr[1] = 5'd7; rd_fp[1] = 1'b0;
    #1;
    check("pre_rst_busy_x4", 0, {63'h0, rd_busy[0]}, 64'h1);
    check("pre_rst_byp_x7", 0, rd_data[1], 64'hCAFE);
    rst = 1'b0;
    #1;
    check("midrst_busy_x4", 0, {63'h0, rd_busy[0]}, 64'h0);
    check("midrst_data_x7", 0, rd_data[1], 64'h0);
    @(negedge clk); idle(); #1;
    check("midrst_hold_x7", 0, rd_data[1], 64'h0);
    rst = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++) begin
        mreg[b][a] = '0; mbusy[b][a] = 1'b0;
      end

    // Random traffic against the behavioural model; small address range forces collisions.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int j = 0; j < NWR; j++) begin
        wr_en[j] = ($urandom_range(0, 2) != 0);
        wr_fp[j] = $urandom_range(0, 1);
        wr_addr[j] = 5'($urandom_range(0, 5));
        wr_data[j] = {$urandom, $urandom};
        wr_single[j] = $urandom_range(0, 1);
      end
      iss_valid = $urandom_range(0, 1);
      iss_fp = $urandom_range(0, 1);
      iss_rd = 5'($urandom_range(0, 5));
      for (int i = 0; i < NRD; i++) begin
        rd_addr[i] = 5'($urandom_range(0, 5));
        rd_fp[i] = $urandom_range(0, 1);
      end
      #1;
      for (int i = 0; i < NRD; i++) begin
        logic [63:0] ed;
        logic eb;
        ed = mreg[rd_fp[i]][rd_addr[i]];
        eb = mbusy[rd_fp[i]][rd_addr[i]];
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && wr_fp[j] == rd_fp[i] && wr_addr[j] == rd_addr[i] &&
              !(wr_fp[j] == 1'b0 && wr_addr[j] == 5'd0)) begin
            ed = box(wr_fp[j], wr_single[j], wr_data[j]);
            eb = 1'b0;
          end
        check("rnd_data", c, rd_data[i], ed);
        check("rnd_busy", c, {63'h0, rd_busy[i]}, {63'h0, eb});
      end
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && !(wr_fp[j] == 1'b0 && wr_addr[j] == 5'd0)) begin
          mreg[wr_fp[j]][wr_addr[j]] = box(wr_fp[j], wr_single[j], wr_data[j]);
          mbusy[wr_fp[j]][wr_addr[j]] = 1'b0;
        end
      if (iss_valid && !(iss_fp == 1'b0 && iss_rd == 5'd0))
        mbusy[iss_fp][iss_rd] = 1'b1;
    end

    @(negedge clk); idle();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
